// File: rtl/tile_flip_controller.sv
`default_nettype none
// ============================================================================
// Module   : tile_flip_controller
// Purpose  : 4x4 tile-flip game sequencer driving a frame-synchronous
//            face-up mask to the VGA display block.
// Revision : 1.0 - initial release
// ============================================================================
module tile_flip_controller #(
  parameter int MISMATCH_FRAMES = 60
) (
  input  logic        in_clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic [47:0] tile_vals,
  input  logic        level_load,
  input  logic        sel_valid,
  input  logic [3:0]  sel_idx,
  output logic        sel_ready,
  output logic        sel_reject,
  output logic [15:0] states,
  output logic [15:0] matched,
  output logic [7:0]  moves,
  output logic        game_done
);

  localparam logic [7:0] c_mismatch_frames = 8'(MISMATCH_FRAMES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ONE   = 3'd1,
    ST_CHECK = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_vs_s1, r_vs_s2, r_vs_s3;
  logic [15:0] r_faceup, w_faceup_nxt;
  logic [15:0] r_matched, w_matched_nxt;
  logic [15:0] r_states, w_states_nxt;
  logic [7:0]  r_moves, w_moves_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [3:0]  r_a, w_a_nxt;
  logic [3:0]  r_b, w_b_nxt;
  logic        r_reject, w_reject_nxt;

  logic        w_tick;
  logic [15:0] w_pend;
  logic        w_ready;
  logic        w_accept;
  logic [7:0]  w_cnt_inc;
  logic [2:0]  w_col [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_col
    assign w_col[gi] = tile_vals[3*gi +: 3];
  end

  assign w_tick    = r_vs_s3 & ~r_vs_s2;
  assign w_pend    = r_matched | r_faceup;
  assign w_ready   = (r_state == ST_IDLE) || (r_state == ST_ONE);
  // A face-up tile (including A while in ONE) is never a legal pick.
  assign w_accept  = sel_valid & w_ready & ~w_pend[sel_idx] & ~level_load;
  assign w_cnt_inc = r_cnt + 8'd1;

  always_comb begin
    w_state_nxt   = r_state;
    w_faceup_nxt  = r_faceup;
    w_matched_nxt = r_matched;
    w_moves_nxt   = r_moves;
    w_cnt_nxt     = r_cnt;
    w_a_nxt       = r_a;
    w_b_nxt       = r_b;
    w_states_nxt  = w_tick ? w_pend : r_states;
    w_reject_nxt  = sel_valid & ~level_load & (~w_ready | w_pend[sel_idx]);

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_faceup_nxt[sel_idx] = 1'b1;
          w_a_nxt               = sel_idx;
          w_state_nxt           = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_accept) begin
          w_faceup_nxt[sel_idx] = 1'b1;
          w_b_nxt               = sel_idx;
          w_state_nxt           = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (r_moves != 8'hFF) w_moves_nxt = r_moves + 8'd1;
        if (w_col[r_a] == w_col[r_b]) begin
          w_matched_nxt = r_matched | (16'd1 << r_a) | (16'd1 << r_b);
          w_faceup_nxt  = 16'd0;
          w_state_nxt   = (w_matched_nxt == 16'hFFFF) ? ST_DONE : ST_IDLE;
        end else begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_tick) begin
          if (w_cnt_inc == c_mismatch_frames) begin
            w_faceup_nxt[r_a] = 1'b0;
            w_faceup_nxt[r_b] = 1'b0;
            w_cnt_nxt         = 8'd0;
            w_state_nxt       = ST_IDLE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      ST_DONE: ;
      default: w_state_nxt = ST_IDLE;
    endcase

    // Display mask is deliberately left alone; it catches up on the next tick.
    if (level_load) begin
      w_faceup_nxt  = 16'd0;
      w_matched_nxt = 16'd0;
      w_moves_nxt   = 8'd0;
      w_cnt_nxt     = 8'd0;
      w_state_nxt   = ST_IDLE;
    end
  end

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_s1   <= 1'b1;
      r_vs_s2   <= 1'b1;
      r_vs_s3   <= 1'b1;
      r_faceup  <= 16'd0;
      r_matched <= 16'd0;
      r_states  <= 16'd0;
      r_moves   <= 8'd0;
      r_cnt     <= 8'd0;
      r_a       <= 4'd0;
      r_b       <= 4'd0;
      r_reject  <= 1'b0;
    end else begin
      r_vs_s1   <= vsync;
      r_vs_s2   <= r_vs_s1;
      r_vs_s3   <= r_vs_s2;
      r_faceup  <= w_faceup_nxt;
      r_matched <= w_matched_nxt;
      r_states  <= w_states_nxt;
      r_moves   <= w_moves_nxt;
      r_cnt     <= w_cnt_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_reject  <= w_reject_nxt;
    end
  end

  assign sel_ready  = w_ready;
  assign sel_reject = r_reject;
  assign states     = r_states;
  assign matched    = r_matched;
  assign moves      = r_moves;
  assign game_done  = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_tile_flip_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_flip_controller
// Purpose  : Directed self-checking bench for tile_flip_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_flip_controller;

  logic        in_clk;
  logic        rst_n;
  logic        vsync;
  logic [47:0] tile_vals;
  logic        level_load;
  logic        sel_valid;
  logic [3:0]  sel_idx;
  logic        sel_ready;
  logic        sel_reject;
  logic [15:0] states;
  logic [15:0] matched;
  logic [7:0]  moves;
  logic        game_done;

  int r_errors = 0;
  int r_checks = 0;

  tile_flip_controller #(.MISMATCH_FRAMES(3)) dut (
    .in_clk    (in_clk),
    .rst_n     (rst_n),
    .vsync     (vsync),
    .tile_vals (tile_vals),
    .level_load(level_load),
    .sel_valid (sel_valid),
    .sel_idx   (sel_idx),
    .sel_ready (sel_ready),
    .sel_reject(sel_reject),
    .states    (states),
    .matched   (matched),
    .moves     (moves),
    .game_done (game_done)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    r_checks++;
    if (got !== exp) begin
      r_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_col(input int idx, input logic [2:0] c);
    tile_vals[3*idx +: 3] = c;
  endtask

  task automatic step();
    @(negedge in_clk);
  endtask

  // One vsync low pulse, then enough cycles for the tick to land on states.
  task automatic frame();
    @(negedge in_clk) vsync = 1'b0;
    repeat (3) @(negedge in_clk);
    vsync = 1'b1;
    repeat (4) @(negedge in_clk);
  endtask

  task automatic pick(input logic [3:0] idx, input logic exp_rej, input string tag);
    @(negedge in_clk);
    sel_valid = 1'b1;
    sel_idx   = idx;
    @(negedge in_clk);
    sel_valid = 1'b0;
    check_eq(tag, 32'(sel_reject), 32'(exp_rej));
  endtask

  task automatic pulse_load();
    @(negedge in_clk) level_load = 1'b1;
    @(negedge in_clk) level_load = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    vsync      = 1'b1;
    level_load = 1'b0;
    sel_valid  = 1'b0;
    sel_idx    = 4'd0;
    tile_vals  = '0;
    set_col(0, 3'd2); set_col(1, 3'd2);
    set_col(2, 3'd1); set_col(3, 3'd5);
    for (int k = 2; k < 8; k++) begin
      set_col(2*k, 3'(k)); set_col(2*k+1, 3'(k));
    end
    repeat (3) @(negedge in_clk);
    rst_n = 1'b1;

    // Reset state
    step();
    check_eq("rst_states",  32'(states), 32'h0);
    check_eq("rst_matched", 32'(matched), 32'h0);
    check_eq("rst_moves",   32'(moves), 32'h0);
    check_eq("rst_ready",   32'(sel_ready), 32'h1);
    check_eq("rst_done",    32'(game_done), 32'h0);
    frame();
    check_eq("t1_states",   32'(states), 32'h0);

    // Matching pair 0/1
    pick(4'd0, 1'b0, "t2_rej0");
    check_eq("t2_states_pre", 32'(states), 32'h0);
    pick(4'd1, 1'b0, "t2_rej1");
    step();
    check_eq("t2_matched", 32'(matched), 32'h0003);
    check_eq("t2_moves",   32'(moves), 32'h1);
    check_eq("t2_ready",   32'(sel_ready), 32'h1);
    frame();
    check_eq("t2_states",  32'(states), 32'h0003);

    // Mismatch 2/3 held for three frames
    pick(4'd2, 1'b0, "t3_rej2");
    pick(4'd3, 1'b0, "t3_rej3");
    step();
    check_eq("t3_ready_hold", 32'(sel_ready), 32'h0);
    check_eq("t3_moves",      32'(moves), 32'h2);
    check_eq("t3_matched",    32'(matched), 32'h0003);
    frame();
    check_eq("t3_states_f1",  32'(states), 32'h000F);
    check_eq("t3_ready_f1",   32'(sel_ready), 32'h0);
    pick(4'd8, 1'b1, "t3_rej_hold");
    frame();
    check_eq("t3_ready_f2",   32'(sel_ready), 32'h0);
    frame();
    check_eq("t3_ready_f3",   32'(sel_ready), 32'h1);
    check_eq("t3_states_f3",  32'(states), 32'h000F);
    frame();
    check_eq("t3_states_f4",  32'(states), 32'h0003);

    // Rejects: repeated tile, matched tile
    pick(4'd5, 1'b0, "t4_rej5a");
    pick(4'd5, 1'b1, "t4_rej5b");
    step();
    check_eq("t4_rej_pulse", 32'(sel_reject), 32'h0);
    check_eq("t4_ready",     32'(sel_ready), 32'h1);
    pick(4'd0, 1'b1, "t4_rej_matched");
    check_eq("t4_moves",     32'(moves), 32'h2);
    pick(4'd4, 1'b0, "t4_rej4");
    step();
    check_eq("t4_matched",   32'(matched), 32'h0033);
    check_eq("t4_moves2",    32'(moves), 32'h3);

    // Finish the board
    set_col(3, 3'd1);
    for (int p = 0; p < 6; p++) begin
      logic [3:0] lo;
      lo = (p == 0) ? 4'd2 : 4'(2*p + 4);
      pick(lo, 1'b0, "t5_rej_lo");
      pick(lo + 4'd1, 1'b0, "t5_rej_hi");
      step();
    end
    check_eq("t5_matched", 32'(matched), 32'hFFFF);
    check_eq("t5_moves",   32'(moves), 32'h9);
    check_eq("t5_done",    32'(game_done), 32'h1);
    check_eq("t5_ready",   32'(sel_ready), 32'h0);
    frame();
    check_eq("t5_states",  32'(states), 32'hFFFF);
    pick(4'd0, 1'b1, "t5_rej_done");
    pulse_load();
    check_eq("t5_load_done",    32'(game_done), 32'h0);
    check_eq("t5_load_matched", 32'(matched), 32'h0);
    check_eq("t5_load_moves",   32'(moves), 32'h0);
    check_eq("t5_load_states",  32'(states), 32'hFFFF);
    frame();
    check_eq("t5_states_clr",   32'(states), 32'h0);

    // level_load beats a simultaneous pick in ONE
    pick(4'd0, 1'b0, "t6_rej0");
    @(negedge in_clk);
    sel_valid  = 1'b1;
    sel_idx    = 4'd1;
    level_load = 1'b1;
    @(negedge in_clk);
    sel_valid  = 1'b0;
    level_load = 1'b0;
    step();
    check_eq("t6_ready",   32'(sel_ready), 32'h1);
    check_eq("t6_matched", 32'(matched), 32'h0);
    check_eq("t6_moves",   32'(moves), 32'h0);
    frame();
    check_eq("t6_states",  32'(states), 32'h0);
    pick(4'd2, 1'b0, "t6_rej2");
    pick(4'd3, 1'b0, "t6_rej3");
    step();
    check_eq("t6_matched2", 32'(matched), 32'h000C);
    check_eq("t6_moves2",   32'(moves), 32'h1);

    // Asynchronous reset in the middle of HOLD
    set_col(5, 3'd7);
    pick(4'd4, 1'b0, "t6_rej4");
    pick(4'd5, 1'b0, "t6_rej5");
    step();
    check_eq("t6_hold_ready", 32'(sel_ready), 32'h0);
    frame();
    check_eq("t6_hold_states", 32'(states), 32'h003C);
    @(negedge in_clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_states",  32'(states), 32'h0);
    check_eq("t6_rst_matched", 32'(matched), 32'h0);
    check_eq("t6_rst_moves",   32'(moves), 32'h0);
    check_eq("t6_rst_done",    32'(game_done), 32'h0);
    check_eq("t6_rst_reject",  32'(sel_reject), 32'h0);
    check_eq("t6_rst_ready",   32'(sel_ready), 32'h1);
    @(negedge in_clk) rst_n = 1'b1;
    frame();
    check_eq("t6_post_states", 32'(states), 32'h0);

    $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
    $finish;
  end

endmodule
`default_nettype wire
